mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and select controller for the 4:1 mux datapath. It shares one mux output between four requesters, drives the 2-bit select (S1,S0), and registers the selected data. Each grant is held for a bounded number of cycles so no requester can starve the others. It sits directly in front of the 4:1 mux consumer and replaces free-running or testbench-driven select sequencing.

## Interface
Parameters:
- DW, 1: data width of each mux input and of y.
- MAX_HOLD, 4: maximum consecutive grant cycles per requester. Legal range 1..255. The hold counter is 8 bits.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  request vector; bit k is requester k.
- i0, i1, i2, i3  in  DW each  mux data inputs; ik belongs to requester k.
- sel  out  2  mux select, {S1,S0}. Equals the index of the granted requester.
- gnt  out  4  one-hot grant, or 0 when idle.
- busy  out  1  high while in GRANT state.
- y  out  DW  registered mux output.
- y_valid  out  1  y holds data from a valid grant cycle.

## Operation
- Two states:
  - IDLE: gnt=0, busy=0.
  - GRANT: gnt one-hot, busy=1.
- Priority pointer ptr (2 bits) names the highest-priority requester. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- Arbitration is a priority search over req starting at ptr.
  - The winner k loads gnt=1<<k, sel=k and hold_cnt=1.
- IDLE:
  - If req≠0, arbitrate and enter GRANT.
  - Otherwise stay in IDLE. sel holds its last value.
- GRANT with current owner c: a release occurs at an edge when req[c]=0 or hold_cnt==MAX_HOLD.
  - No release: hold_cnt increments and gnt/sel are unchanged.
  - On release, ptr<=c+1 mod 4 and arbitration runs on the same edge using the new pointer and the current req.
    - If any req remains, the new winner is granted with no idle cycle. If c is the only requester left, c is re-granted and hold_cnt resets to 1.
    - If no req remains, go to IDLE with gnt=0.
- Datapath, every edge:
  - y <= i[sel] if gnt[sel] & req[sel]; otherwise y holds.
  - y_valid <= gnt[sel] & req[sel].
- Widths:
  - sel+1 wraps from 3 to 0.
  - hold_cnt never exceeds MAX_HOLD.
  - With MAX_HOLD=1, every grant lasts exactly one cycle. Under full load this gives strict rotation.
- Reset, asserted at any time including mid-grant, takes effect immediately and asynchronously:
  - gnt=0, sel=0, busy=0, y=0, y_valid=0.
  - ptr=0, hold_cnt=0, state IDLE.
  - The first arbitration after reset release starts from requester 0.

## Timing
- Request to grant: 1 cycle. req sampled at edge E gives gnt/sel valid after E.
- Grant to data: 1 cycle. i[sel] present during grant cycle n appears on y after edge n+1, together with y_valid=1.
- Handover between owners: 0 idle cycles. gnt changes directly from one one-hot value to the next.
- A requester dropping req during its own grant cycle:
  - That cycle produces no valid data (y_valid=0 next).
  - The grant moves on at that same edge.
- Request changes by non-owners during a grant affect only the next arbitration.
- Simultaneous events:
  - If a release coincides with new requests, those requests compete at that edge.
  - If the owner drops req at the same time as hold expiry, it is treated as a single release.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111.
  - During reset: gnt=0, sel=0, y=0, y_valid=0, busy=0.
  - After release, first edge: gnt=4'b0001, sel=2'b00, busy=1.
- Full load, MAX_HOLD=4, req=4'b1111 held for 20 cycles:
  - gnt sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001×4.
  - sel sequence 0,1,2,3,0. No gaps.
- Single requester, req=4'b0100 for 10 cycles:
  - gnt=0100 and sel=2'b10 continuously; hold_cnt re-arms at cycles 4 and 8.
  - y_valid=1 from cycle 2 through the cycle after req drops.
- Early release: req=4'b0110. req[1] drops after 2 grant cycles.
  - gnt goes 0010, 0010, 0100 with no gap.
  - ptr=2, then after req[2] releases the search starts at 3.
- Data, DW=8: i0..i3 = 8'hA0, 8'hA1, 8'hA2, 8'hA3 under full load.
  - y shows A0×4, A1×4, A2×4, A3×4, lagging gnt by one cycle.
  - y_valid falls one cycle after req goes to 0 and busy=0.
- Mid-grant reset: assert rst_n=0 asynchronously (between edges) during the third cycle of the grant to requester 2.
  - gnt, sel, y and y_valid clear immediately.
  - After release with req=4'b0100: gnt=0100 after 1 edge, with a fresh hold count.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4:1 mux: bounded-hold grants, select drive and registered output.
// Grant 1 cycle after request, data 1 cycle after grant; handover between owners has no idle cycle.
module mux4_rr_arbiter #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  output logic [1:0]    sel,
  output logic [3:0]    gnt,
  output logic          busy,
  output logic [DW-1:0] y,
  output logic          y_valid
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [7:0]    hold_q, hold_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [DW-1:0] y_q, y_d;
  logic          y_valid_q, y_valid_d;

  logic [1:0]    arb_ptr;
  logic [1:0]    winner;
  logic          release_c;
  logic          grant_ok;
  logic [DW-1:0] mux_dat;

  // Lowest offset from the pointer wins, so scan offsets high-to-low and let later hits override.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // On a release the pointer moves past the owner on the same edge, so arbitrate from there.
  assign arb_ptr   = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
  assign winner    = rr_pick(req, arb_ptr);
  assign release_c = !req[sel_q] || (hold_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d = sel_q + 2'd1;
          if (|req) begin
            gnt_d  = 4'b0001 << winner;
            sel_d  = winner;
            hold_d = 8'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = 8'd0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    mux_dat = i0;
    case (sel_q)
      2'd0: mux_dat = i0;
      2'd1: mux_dat = i1;
      2'd2: mux_dat = i2;
      2'd3: mux_dat = i3;
      default: mux_dat = i0;
    endcase
  end

  assign grant_ok  = gnt_q[sel_q] & req[sel_q];
  assign y_d       = grant_ok ? mux_dat : y_q;
  assign y_valid_d = grant_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      sel_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = (state_q == GRANT);
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: vector table for rotation/hold/handover, plus hand sequences for reset cases.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] i0, i1, i2, i3;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic [7:0] y;
  logic       y_valid;

  logic [1:0] sel1;
  logic [3:0] gnt1;
  logic       busy1;
  logic [0:0] y1;
  logic       y_valid1;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .sel(sel), .gnt(gnt), .busy(busy), .y(y), .y_valid(y_valid)
  );

  mux4_rr_arbiter #(.DW(1), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .i0(i0[0:0]), .i1(i1[0:0]), .i2(i2[0:0]), .i3(i3[0:0]),
    .sel(sel1), .gnt(gnt1), .busy(busy1), .y(y1), .y_valid(y_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       yv;
    logic [7:0] y;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic v, input logic [7:0] d);
    vec_t e;
    e.req = r; e.gnt = g; e.sel = s; e.busy = b; e.yv = v; e.y = d;
    tbl.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int own;
    int prev;
    rst_n = 1'b0;
    req   = 4'b1111;
    i0 = 8'hA0; i1 = 8'hA1; i2 = 8'hA2; i3 = 8'hA3;

    // Full load with MAX_HOLD=4: four cycles per owner, y trails gnt by one cycle.
    for (int k = 0; k < 20; k++) begin
      own  = (k / 4) % 4;
      prev = ((k - 1) / 4) % 4;
      if (k == 0) add(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h00);
      else        add(4'b1111, 4'b0001 << own, 2'(own), 1'b1, 1'b1, 8'hA0 + 8'(prev));
    end
    // Owner drops exactly at hold expiry: single release into IDLE, sel holds.
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hA0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hA0);
    // Lone requester 2: continuous grant with silent re-arm.
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'hA0);
    for (int k = 0; k < 9; k++) add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, 8'hA2);
    // Early release of requester 1, then requester 2 releases and the search starts at 3.
    add(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0, 8'hA2);
    add(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1, 8'hA1);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'hA1);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2);
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, 8'hA2);
    add(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, 8'hA2);

    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_yv", 32'(y_valid), 32'h0);
    chk("rst_gnt_h1", 32'(gnt1), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[n]) begin
      req = tbl[n].req;
      tick();
      chk($sformatf("v%0d_gnt", n), 32'(gnt), 32'(tbl[n].gnt));
      chk($sformatf("v%0d_sel", n), 32'(sel), 32'(tbl[n].sel));
      chk($sformatf("v%0d_busy", n), 32'(busy), 32'(tbl[n].busy));
      chk($sformatf("v%0d_yv", n), 32'(y_valid), 32'(tbl[n].yv));
      chk($sformatf("v%0d_y", n), 32'(y), 32'(tbl[n].y));
      if (n < 20) chk($sformatf("v%0d_gnt_h1", n), 32'(gnt1), 32'(4'b0001 << (n % 4)));
    end

    // Asynchronous reset in the third cycle of a grant to requester 2.
    req = 4'b0100;
    tick();
    tick();
    tick();
    chk("mid_pre_gnt", 32'(gnt), 32'h4);
    chk("mid_pre_y", 32'(y), 32'hA2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_y", 32'(y), 32'h0);
    chk("mid_rst_yv", 32'(y_valid), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_gnt", 32'(gnt), 32'h4);
    chk("post_sel", 32'(sel), 32'h2);
    chk("post_busy", 32'(busy), 32'h1);
    chk("post_yv", 32'(y_valid), 32'h0);
    // A fresh hold count keeps requester 2 for three more edges before handing to 1.
    req = 4'b0110;
    tick();
    tick();
    tick();
    chk("post_hold4_gnt", 32'(gnt), 32'h4);
    tick();
    chk("post_hand_gnt", 32'(gnt), 32'h2);
    chk("post_hand_sel", 32'(sel), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
